// File: rtl/ines_loader.sv
// ines_loader: streams an iNES image into cart memory (PRG at 0x000000, CHR at 0x200000) and builds the mapper flags word.
// Optional macro INES_TRAINER_SKIP_EN: skip a 512-byte trainer instead of rejecting images that carry one.
module ines_loader #(
    parameter int PRG_MAX_BANKS = 128,
    parameter int CHR_MAX_BANKS = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  indata,
    input  logic        indata_clk,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_write,
    output logic [31:0] mapper_flags,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {
        S_HEADER,
`ifdef INES_TRAINER_SKIP_EN
        S_TRAINER,
`endif
        S_PRG,
        S_CHR,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      r_state;
    logic [21:0] r_cnt;
    logic [7:0]  r_hdr4, r_hdr5, r_hdr6;
    logic [3:0]  r_hdr7;
    logic [21:0] r_mem_addr;
    logic [7:0]  r_mem_data;
    logic        r_mem_write;
    logic [31:0] r_flags;
    logic [7:0]  w_magic;
    logic [21:0] w_prg_last, w_chr_last;

    // Bank-count codes: ceil(log2(v)), 0 for v<=1, saturated to 3 bits.
    function automatic logic [2:0] f_clog2(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++)
            if (v > (8'd1 << i)) n = 4'(i + 1);
        return (n > 4'd7) ? 3'd7 : n[2:0];
    endfunction

    always_comb begin
        w_magic = (r_cnt[1:0] == 2'd0) ? 8'h4E :
                  (r_cnt[1:0] == 2'd1) ? 8'h45 :
                  (r_cnt[1:0] == 2'd2) ? 8'h53 : 8'h1A;
    end

    // 22-bit sizes: hdr4=128 lands exactly on 0x200000 without wrapping.
    assign w_prg_last   = {r_hdr4, 14'd0} - 22'd1;
    assign w_chr_last   = {1'b0, r_hdr5, 13'd0} - 22'd1;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign mem_write    = r_mem_write;
    assign mapper_flags = r_flags;
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_HEADER;
            r_cnt       <= 22'd0;
            r_hdr4      <= 8'd0;
            r_hdr5      <= 8'd0;
            r_hdr6      <= 8'd0;
            r_hdr7      <= 4'd0;
            r_mem_addr  <= 22'd0;
            r_mem_data  <= 8'd0;
            r_mem_write <= 1'b0;
            r_flags     <= 32'd0;
        end else begin
            r_mem_write <= 1'b0;
            if (indata_clk) begin
                case (r_state)
                    S_HEADER: begin
                        r_cnt <= r_cnt + 22'd1;
                        if (r_cnt[3:2] == 2'd0 && indata != w_magic) r_state <= S_ERROR;
                        case (r_cnt[3:0])
                            4'd4: begin
                                r_hdr4 <= indata;
                                if (indata == 8'd0 || {1'b0, indata} > 9'(PRG_MAX_BANKS)) r_state <= S_ERROR;
                            end
                            4'd5: begin
                                r_hdr5 <= indata;
                                if ({1'b0, indata} > 9'(CHR_MAX_BANKS)) r_state <= S_ERROR;
                            end
                            4'd6: r_hdr6 <= indata;
                            4'd7: r_hdr7 <= indata[7:4];
                            4'd15: begin
                                r_cnt   <= 22'd0;
                                r_flags <= {14'd0, r_hdr6[3], r_hdr6[1], r_hdr5 == 8'd0, r_hdr6[0],
                                            f_clog2(r_hdr5), f_clog2(r_hdr4), r_hdr7, r_hdr6[7:4]};
`ifdef INES_TRAINER_SKIP_EN
                                r_state <= r_hdr6[2] ? S_TRAINER : S_PRG;
`else
                                r_state <= r_hdr6[2] ? S_ERROR : S_PRG;
`endif
                            end
                            default: ;
                        endcase
                    end
`ifdef INES_TRAINER_SKIP_EN
                    S_TRAINER: begin
                        r_cnt <= r_cnt + 22'd1;
                        if (r_cnt == 22'd511) begin
                            r_cnt   <= 22'd0;
                            r_state <= S_PRG;
                        end
                    end
`endif
                    S_PRG: begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {1'b0, r_cnt[20:0]};
                        r_mem_data  <= indata;
                        r_cnt       <= r_cnt + 22'd1;
                        if (r_cnt == w_prg_last) begin
                            r_cnt   <= 22'd0;
                            r_state <= (r_hdr5 != 8'd0) ? S_CHR : S_DONE;
                        end
                    end
                    S_CHR: begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {1'b1, r_cnt[20:0]};
                        r_mem_data  <= indata;
                        r_cnt       <= r_cnt + 22'd1;
                        if (r_cnt == w_chr_last) begin
                            r_cnt   <= 22'd0;
                            r_state <= S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ines_loader.sv
// tb_ines_loader: directed self-checking bench for ines_loader.
module tb_ines_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  indata = 8'd0;
    logic        indata_clk = 1'b0;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;
    logic [31:0] mapper_flags;
    logic        done;
    logic        error;
    int errors = 0;
    int checks = 0;
    int wr_bad = 0;

    always #5 clk = ~clk;

    ines_loader dut (
        .clk(clk), .reset_n(reset_n), .indata(indata), .indata_clk(indata_clk),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .mapper_flags(mapper_flags), .done(done), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 13) ^ (i >> 8));
    endfunction

    // One strobe per cycle; the write it causes is checked one cycle later (inputs change #1 after the edge).
    task automatic send(input logic [7:0] b, input logic w, input logic [21:0] a);
        indata = b;
        indata_clk = 1'b1;
        @(posedge clk);
        #1;
        indata_clk = 1'b0;
        if (mem_write !== w || (w && (mem_addr !== a || mem_data !== b))) wr_bad++;
    endtask

    task automatic send_hdr(input logic [7:0] h4, input logic [7:0] h5, input logic [7:0] h6,
                            input logic [7:0] h7, input int n);
        logic [7:0] h [16];
        h = '{8'h4E, 8'h45, 8'h53, 8'h1A, h4, h5, h6, h7,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < n; i++) send(h[i], 1'b0, 22'd0);
    endtask

    task automatic send_sec(input logic top, input int from, input int to);
        for (int i = from; i < to; i++) send(pat(i), 1'b1, {top, 21'(i)});
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_bad = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", 32'(mem_write), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_flags", mapper_flags, 32'd0);
        chk("rst_done_error", {done, error}, 32'd0);
        reset_n = 1'b1;

        send_hdr(8'h02, 8'h00, 8'h12, 8'h40, 16);
        chk("img2_flags", mapper_flags, 32'h00018141);
        send_sec(1'b0, 0, 32767);
        chk("img2_done_early", 32'(done), 32'd0);
        send_sec(1'b0, 32767, 32768);
        chk("img2_done", 32'(done), 32'd1);
        chk("img2_last_wr", {mem_write, mem_addr}, {9'd0, 1'b1, 22'h007FFF});
        for (int i = 0; i < 3; i++) send(8'hFF, 1'b0, 22'd0);
        chk("img2_writes", wr_bad, 32'd0);
        chk("img2_sticky", {done, error}, 32'd2);

        do_reset;
        send(8'h4F, 1'b0, 22'd0);
        chk("magic_error", 32'(error), 32'd1);
        for (int i = 0; i < 4; i++) send(8'h45, 1'b0, 22'd0);
        chk("magic_nowrite", wr_bad, 32'd0);
        chk("magic_sticky", {done, error}, 32'd1);

        do_reset;
        send_hdr(8'h00, 8'h01, 8'h00, 8'h00, 4);
        chk("hdr4_pre", 32'(error), 32'd0);
        send(8'h00, 1'b0, 22'd0);
        chk("hdr4_zero", 32'(error), 32'd1);

        do_reset;
        send_hdr(8'h00, 8'h01, 8'h00, 8'h00, 4);
        send(8'h80, 1'b0, 22'd0);
        chk("hdr4_0x80_ok", 32'(error), 32'd0);
        do_reset;
        send_hdr(8'h00, 8'h01, 8'h00, 8'h00, 4);
        send(8'h81, 1'b0, 22'd0);
        chk("hdr4_0x81", 32'(error), 32'd1);

        do_reset;
        send_hdr(8'h01, 8'h01, 8'h04, 8'h00, 15);
        chk("trainer_pre", 32'(error), 32'd0);
        send(8'h00, 1'b0, 22'd0);
`ifdef INES_TRAINER_SKIP_EN
        chk("trainer_skip", 32'(error), 32'd0);
        for (int i = 0; i < 512; i++) send(pat(i), 1'b0, 22'd0);
        send(8'hA5, 1'b1, 22'd0);
        chk("trainer_prg0", wr_bad, 32'd0);
`else
        chk("trainer_reject", 32'(error), 32'd1);
        send(8'hA5, 1'b0, 22'd0);
        chk("trainer_nowrite", wr_bad, 32'd0);
`endif

        do_reset;
        send_hdr(8'h01, 8'h01, 8'h01, 8'h00, 16);
        send_sec(1'b0, 0, 1000);
        chk("abort_pre_wr", {mem_write, mem_addr}, {9'd0, 1'b1, 22'd999});
        chk("abort_pre_writes", wr_bad, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("abort_write", 32'(mem_write), 32'd0);
        chk("abort_addr_data", {2'd0, mem_addr, mem_data}, 32'd0);
        chk("abort_flags", mapper_flags, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_bad = 0;

        send_hdr(8'h01, 8'h01, 8'h01, 8'h00, 16);
        chk("img1_flags", mapper_flags, 32'h00004000);
        send_sec(1'b0, 0, 16384);
        chk("img1_prg_end", {done, mem_write, mem_addr}, {8'd0, 2'b01, 22'h003FFF});
        send_sec(1'b1, 0, 8191);
        chk("img1_done_early", 32'(done), 32'd0);
        send_sec(1'b1, 8191, 8192);
        chk("img1_done", 32'(done), 32'd1);
        chk("img1_last_wr", {mem_write, mem_addr}, {9'd0, 1'b1, 22'h201FFF});
        chk("img1_writes", wr_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
